// File: rtl/timer_bank.sv
// Bank of prescaled/cascadable up-counters with reload, wrap pulses and irq.
// One shared 10-bit divider supplies clock-enable ticks to every channel.
module timer_bank #(
  parameter int NUM_CH = 4,
  parameter int WIDTH = 16,
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clock_16,
  input  logic                    reset,
  input  logic                    wr_valid,
  input  logic [SW-1:0]           wr_sel,
  input  logic                    wr_ctrl,
  input  logic [WIDTH-1:0]        wr_data,
  output logic [NUM_CH*WIDTH-1:0] count_flat,
  output logic [NUM_CH-1:0]       overflow,
  output logic [NUM_CH-1:0]       irq_pulse
);

  typedef logic [WIDTH-1:0] word_t;

  word_t             cnt_q [NUM_CH];
  word_t             cnt_d [NUM_CH];
  word_t             rld_q [NUM_CH];
  word_t             rld_d [NUM_CH];
  logic [1:0]        psc_q [NUM_CH];
  logic [1:0]        psc_d [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] ie_q, ie_d;
  logic [NUM_CH-1:0] cas_q, cas_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] irq_q, irq_d;
  logic [9:0]        div_q;
  logic [3:0]        tick;
  logic              unused_wr;

  assign unused_wr = ^(wr_data & ~word_t'(8'hC7));

  assign tick = {&div_q, &div_q[7:0], &div_q[5:0], 1'b1};

  // carry ripples wraps down the chain so a full cascade settles in one cycle
  always_comb begin
    logic carry;
    logic evt;
    logic hit;
    carry = 1'b0;
    evt   = 1'b0;
    hit   = 1'b0;
    ovf_d = '0;
    irq_d = '0;
    en_d  = en_q;
    ie_d  = ie_q;
    cas_d = cas_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      rld_d[i] = rld_q[i];
      psc_d[i] = psc_q[i];
      hit = wr_valid && (int'(wr_sel) == i);
      evt = en_q[i] &&
            ((i > 0 && cas_q[i]) ? carry : tick[psc_q[i]]);
      ovf_d[i] = evt && (&cnt_q[i]);
      irq_d[i] = ovf_d[i] && ie_q[i];
      carry    = ovf_d[i];
      if (hit && wr_ctrl && wr_data[7] && !en_q[i])
        cnt_d[i] = rld_q[i];
      else if (ovf_d[i])
        cnt_d[i] = rld_q[i];
      else if (evt)
        cnt_d[i] = cnt_q[i] + 1'b1;
      if (hit && wr_ctrl) begin
        en_d[i]  = wr_data[7];
        ie_d[i]  = wr_data[6];
        cas_d[i] = wr_data[2];
        psc_d[i] = wr_data[1:0];
      end
      if (hit && !wr_ctrl)
        rld_d[i] = wr_data;
    end
  end

  always_ff @(posedge clock_16 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        rld_q[i] <= '0;
        psc_q[i] <= '0;
      end
      en_q  <= '0;
      ie_q  <= '0;
      cas_q <= '0;
      ovf_q <= '0;
      irq_q <= '0;
      div_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        rld_q[i] <= rld_d[i];
        psc_q[i] <= psc_d[i];
      end
      en_q  <= en_d;
      ie_q  <= ie_d;
      cas_q <= cas_d;
      ovf_q <= ovf_d;
      irq_q <= irq_d;
      div_q <= div_q + 10'd1;
    end
  end

  always_comb begin
    count_flat = '0;
    for (int i = 0; i < NUM_CH; i++)
      count_flat[i*WIDTH +: WIDTH] = cnt_q[i];
  end

  assign overflow  = ovf_q;
  assign irq_pulse = irq_q;

endmodule

// File: tb/tb_timer_bank.sv
// Random + directed bench for timer_bank against a cycle-level
// arithmetic model of the timer rules.
module tb_timer_bank;

  localparam int NCH = 4;
  localparam int W = 16;
  localparam int unsigned MAXV = 32'h0000_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_valid = 1'b0;
  logic [1:0] wr_sel = '0;
  logic wr_ctrl = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic [NCH*W-1:0] count_flat;
  logic [NCH-1:0] overflow;
  logic [NCH-1:0] irq_pulse;

  int n_chk = 0;
  int n_fail = 0;

  int unsigned m_cnt [NCH];
  int unsigned m_rld [NCH];
  int unsigned m_psc [NCH];
  bit m_en [NCH];
  bit m_ie [NCH];
  bit m_cas [NCH];
  bit [NCH-1:0] m_ovf;
  bit [NCH-1:0] m_irq;
  int unsigned m_div;

  timer_bank #(.NUM_CH(NCH), .WIDTH(W)) dut (
    .clock_16(clk),
    .reset(rst),
    .wr_valid(wr_valid),
    .wr_sel(wr_sel),
    .wr_ctrl(wr_ctrl),
    .wr_data(wr_data),
    .count_flat(count_flat),
    .overflow(overflow),
    .irq_pulse(irq_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    return 32'(count_flat[i*W +: W]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_rld[i] = 0; m_psc[i] = 0;
      m_en[i] = 0; m_ie[i] = 0; m_cas[i] = 0;
    end
    m_ovf = '0;
    m_irq = '0;
    m_div = 0;
  endtask

  task automatic model_edge(input bit v, input int s, input bit c,
                            input int unsigned d);
    bit carry;
    bit fire;
    int unsigned period;
    carry = 0;
    for (int i = 0; i < NCH; i++) begin
      period = 1 << ((m_psc[i] == 0) ? 0 : m_psc[i] * 2 + 4);
      if (i > 0 && m_cas[i]) fire = m_en[i] && carry;
      else fire = m_en[i] && (m_div % period == period - 1);
      m_ovf[i] = 0;
      if (fire) begin
        if (m_cnt[i] == MAXV) begin
          m_cnt[i] = m_rld[i];
          m_ovf[i] = 1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
      m_irq[i] = m_ovf[i] && m_ie[i];
      carry = m_ovf[i];
    end
    if (v && s < NCH) begin
      if (c) begin
        if (d[7] && !m_en[s]) m_cnt[s] = m_rld[s];
        m_en[s] = d[7];
        m_ie[s] = d[6];
        m_cas[s] = d[2];
        m_psc[s] = d & 3;
      end else begin
        m_rld[s] = d & MAXV;
      end
    end
    m_div = (m_div + 1) % 1024;
  endtask

  task automatic compare_all();
    for (int i = 0; i < NCH; i++)
      check($sformatf("cnt%0d", i), cnt_of(i), m_cnt[i]);
    check("ovf", 32'(overflow), 32'(m_ovf));
    check("irq", 32'(irq_pulse), 32'(m_irq));
  endtask

  task automatic step(input bit v, input int s, input bit c,
                      input int unsigned d);
    wr_valid = v;
    wr_sel = 2'(s);
    wr_ctrl = c;
    wr_data = W'(d);
    model_edge(v, s, c, d);
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0);
  endtask

  initial begin
    int unsigned d;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_cnt0", cnt_of(0), 0);
    rst = 1'b0;
    idle(2);

    // wrap every 4 cycles with irq
    step(1, 0, 0, 32'hFFFC);
    step(1, 0, 1, 32'h00C0);
    check("r30_load", cnt_of(0), 32'hFFFC);
    step(0, 0, 0, 0);
    check("r30_d", cnt_of(0), 32'hFFFD);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("r30_max", cnt_of(0), 32'hFFFF);
    check("r30_noovf", 32'(overflow[0]), 0);
    step(0, 0, 0, 0);
    check("r30_wrap", cnt_of(0), 32'hFFFC);
    check("r30_ovf", 32'(overflow[0]), 1);
    check("r30_irq", 32'(irq_pulse[0]), 1);
    step(0, 0, 0, 0);
    check("r30_pulse1", 32'(overflow[0]), 0);
    idle(6);

    // prescaled channel 1
    step(1, 1, 0, 0);
    step(1, 1, 1, 32'h0081);
    idle(200);

    // cascade chain ch0 -> ch1
    step(1, 0, 0, 32'hFFFF);
    step(1, 0, 1, 32'h0000);
    step(1, 0, 1, 32'h0080);
    step(1, 1, 1, 32'h0000);
    step(1, 1, 0, 32'hFFFE);
    step(1, 1, 1, 32'h00C4);
    idle(12);

    // reload rewrite on wrap cycle of ch2
    step(1, 2, 0, 32'hFFFD);
    step(1, 2, 1, 32'h0080);
    step(0, 0, 0, 0);
    step(1, 2, 0, 32'h1234);
    idle(4);

    // stop and restart ch3
    step(1, 3, 0, 32'h0090);
    step(1, 3, 1, 32'h0080);
    idle(16);
    step(1, 3, 1, 32'h0000);
    idle(4);
    step(1, 3, 1, 32'h0080);
    check("r34_restart", cnt_of(3), 32'h0090);
    idle(2);

    // async reset with pulses pending
    step(1, 0, 0, 32'hFFFF);
    step(1, 0, 1, 32'h00C0);
    step(0, 0, 0, 0);
    check("pre_rst_irq", 32'(irq_pulse[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_ovf", 32'(overflow), 0);
    check("arst_irq", 32'(irq_pulse), 0);
    check("arst_cnt0", cnt_of(0), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(5);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(3) == 0) begin
        if ($urandom_range(1) == 0) begin
          if ($urandom_range(1) == 0)
            d = $urandom_range(MAXV, MAXV - 12);
          else
            d = $urandom_range(MAXV);
          step(1, $urandom_range(NCH - 1), 0, d);
        end else begin
          d = $urandom_range(MAXV);
          if ($urandom_range(3) != 0) d = d | 32'h80;
          if ($urandom_range(1) == 0) d = d & ~32'h3;
          step(1, $urandom_range(NCH - 1), 1, d);
        end
      end else begin
        step(0, 0, 0, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of timer channels (1..8).
REQ-002 Parameter WIDTH, default 16, counter/reload width in bits (8..32).
REQ-003 clock_16  in  1  system clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 wr_valid  in  1  register write strobe, one write per cycle.
REQ-006 wr_sel  in  max(1,$clog2(NUM_CH))  target channel; values >= NUM_CH ignored.
REQ-007 wr_ctrl  in  1  0 = write reload register, 1 = write control register.
REQ-008 wr_data  in  WIDTH  write data; control uses bits [7],[6],[2],[1:0] only.
REQ-009 count_flat  out  NUM_CH*WIDTH  live counters, channel i at [i*WIDTH +: WIDTH].
REQ-010 overflow  out  NUM_CH  one-cycle pulse per channel wrap.
REQ-011 irq_pulse  out  NUM_CH  one-cycle pulse = overflow AND irq_en of that channel.

Function
REQ-012 Control fields per channel: enable = bit7, irq_en = bit6, cascade = bit2, prescaler = bits[1:0].
REQ-013 Single clock domain; prescaling by clock-enable strobes only, no derived clocks.
REQ-014 Shared free-running 10-bit divider; tick for prescaler 00 every cycle, 01 when div[5:0]==63, 10 when div[7:0]==255, 11 when div[9:0]==1023.
REQ-015 Increment event (channel i): enable AND (cascade AND i>0 ? overflow[i-1] same cycle : prescaler tick).
REQ-016 Channel 0 ignores cascade bit; uses prescaler tick.
REQ-017 Cascaded channel ignores its prescaler field.
REQ-018 Increment event with counter != all-ones: counter <= counter + 1.
REQ-019 Increment event with counter == all-ones: counter <= reload; overflow[i] = 1 for that cycle; no value all-ones+1 ever appears.
REQ-020 Cascade chain combinational within a cycle: overflow of i and resulting increment of i+1 in same clock edge; full chain wrap (all channels) in one cycle.
REQ-021 Control write setting enable 0->1: counter <= reload at that edge; first increment event evaluated the following cycle.
REQ-022 Control write with enable already 1: counter unchanged; new irq_en/cascade/prescaler apply from next cycle.
REQ-023 Enable 1->0: counter frozen at current value, no overflow/irq; visible on count_flat.
REQ-024 Reload write: reload register updated at the edge; counter unaffected; used at next start or wrap.
REQ-025 Reload write same cycle as wrap of that channel: counter loads OLD reload value.
REQ-026 Control write same cycle as an increment event of that channel: event evaluated with OLD control; start-load (REQ-021) takes priority over increment.
REQ-027 Divider free-runs regardless of channel enables; not cleared by writes.

Reset
REQ-028 Reset asserted: all counters, reload and control registers, divider = 0; overflow, irq_pulse = 0 immediately (asynchronous).
REQ-029 Reset mid-count: no pulse emitted on the reset edge or first cycle after release; channels stay disabled until written.

Verification
REQ-030 Ch0 reload FFFC, ctrl 0x00C0 -> count FFFC,FFFD,FFFE,FFFF, then FFFC with overflow[0]=irq_pulse[0]=1 for exactly 1 cycle; repeats every 4 cycles.
REQ-031 Ch1 reload 0000, ctrl 0x0081 (prescaler 64) -> count advances once per 64 cycles, aligned to div[5:0]==63.
REQ-032 Ch0 reload FFFF ctrl 0x0080; ch1 reload FFFE ctrl 0x00C4 -> ch0 wraps each cycle; ch1 counts FFFE,FFFF, then wraps to FFFE with irq_pulse[1] on every 2nd ch0 overflow, same cycle.
REQ-033 Ch2 running, reload rewritten to 1234 on its wrap cycle -> counter loads old reload; next wrap loads 1234.
REQ-034 Ch3 at 00A0 running, ctrl written 0x0000 -> holds 00A0; ctrl 0x0080 -> restarts at reload, not 00A0.
REQ-035 Reset pulse mid-run with irq pending -> all outputs 0 asynchronously; no pulses after release.
